// File: rtl/iab_bus_arbiter.sv
// iab_bus_arbiter
//   Shares one narrow output bus between NUM_REQ iab instances. A requester
//   raising req is chosen round-robin and gets a one-cycle gnt pulse. Its
//   data_in word is then muxed onto bus_data, and accepted_in is routed back
//   to it, until BEATS words have been accepted.
//
// Optional build macro: IAB_ARB_TIMEOUT_EN
//   Adds a watchdog that aborts a burst after TIMEOUT_CYCLES consecutive
//   XFER edges without accepted_in. Without the macro, timeout_err is
//   constant 0 and XFER waits indefinitely.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   req          in   [NUM_REQ]            reqIAB from each iab
//   data_in      in   [NUM_REQ*DATA_WIDTH] dataOut of iab i at [i*DATA_WIDTH +: DATA_WIDTH]
//   accepted_in  in   consumer acceptedI, one pulse per word taken
//   gnt          out  [NUM_REQ]            one-hot, one-cycle grant pulse
//   accepted_out out  [NUM_REQ]            accepted_in routed to the owner during XFER
//   bus_data     out  [DATA_WIDTH]         owner's word during XFER, else 0
//   bus_valid    out  high while a burst is in progress
//   owner        out  index of the current or last owner
//   busy         out  state != IDLE
//   timeout_err  out  one-cycle watchdog abort pulse
module iab_bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int BEATS          = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  input  logic                          accepted_in,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            accepted_out,
  output logic [DATA_WIDTH-1:0]         bus_data,
  output logic                          bus_valid,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               bus_valid_q, bus_valid_d;
  logic               busy_q, busy_d;

  logic [OW-1:0]      rr_pick;
  logic [OW-1:0]      cand;
  logic               found;
  logic               xfer;
  logic               timeout_hit;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  assign xfer = (state_q == XFER);

  // Split the flat input bus into per-requester words and route the
  // consumer's accept strobe back to the owner only.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign data_arr[gi]     = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
    assign accepted_out[gi] = xfer && accepted_in && (owner_q == OW'(gi));
  end

  assign bus_data = xfer ? data_arr[owner_q] : '0;

  // Round-robin search: first set req bit starting just after the last owner.
  always_comb begin
    rr_pick = owner_q;
    cand    = '0;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = OW'((int'(owner_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  end

`ifdef IAB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          timeout_err_q;

  // Counts consecutive XFER edges without an accept; zero outside XFER so
  // every burst starts with a fresh budget.
  always_comb begin
    idle_cnt_d = '0;
    if (xfer && !accepted_in) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = xfer && (idle_cnt_d == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      idle_cnt_q    <= timeout_hit ? '0 : idle_cnt_d;
      timeout_err_q <= timeout_hit;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = rr_pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d    = XFER;
        beat_cnt_d = '0;
      end
      XFER: begin
        // A watchdog abort keeps owner as the round-robin pointer, exactly
        // like a normal completion.
        if (timeout_hit) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end else if (accepted_in) begin
          if (beat_cnt_q == BW'(BEATS - 1)) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    gnt_d = '0;
    if (state_d == GRANT) begin
      gnt_d[owner_d] = 1'b1;
    end
    bus_valid_d = (state_d == XFER);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OW'(NUM_REQ - 1);
      beat_cnt_q  <= '0;
      gnt_q       <= '0;
      bus_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      gnt_q       <= gnt_d;
      bus_valid_q <= bus_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign bus_valid = bus_valid_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_iab_bus_arbiter.sv
// Self-checking bench for iab_bus_arbiter (NUM_REQ=4, DATA_WIDTH=8, BEATS=8).
// Each table row describes one clock cycle: the inputs driven during that
// cycle and the outputs expected during it (before the closing edge).
module tb_iab_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        acc;
  logic [3:0]  gnt;
  logic [3:0]  acco;
  logic [7:0]  bus_data;
  logic        bus_valid;
  logic [1:0]  owner;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  iab_bus_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .BEATS(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
    .accepted_in(acc), .gnt(gnt), .accepted_out(acco), .bus_data(bus_data),
    .bus_valid(bus_valid), .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       acc;
    logic [3:0] gnt;
    logic [3:0] acco;
    logic       valid;
    logic       busy;
    logic [1:0] owner;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] dat(input logic [1:0] o);
    return 8'hA0 + 8'h11 * o;
  endfunction

  task automatic v(input logic r, input logic [3:0] rq, input logic a,
                   input logic [3:0] g, input logic [3:0] ao, input logic vl,
                   input logic b, input logic [1:0] o, input logic [7:0] d);
    vec_t t;
    t.rst_n = r; t.req = rq; t.acc = a;
    t.gnt = g; t.acco = ao; t.valid = vl; t.busy = b; t.owner = o; t.data = d;
    vecs.push_back(t);
  endtask

  task automatic idle(input logic [3:0] rq, input logic a, input logic [1:0] o);
    v(1'b1, rq, a, 4'b0000, 4'b0000, 1'b0, 1'b0, o, 8'h00);
  endtask

  task automatic grant(input logic [3:0] rq, input logic a, input logic [1:0] o);
    v(1'b1, rq, a, 4'b0001 << o, 4'b0000, 1'b0, 1'b1, o, 8'h00);
  endtask

  task automatic xfer(input logic [3:0] rq, input logic a, input logic [1:0] o);
    v(1'b1, rq, a, 4'b0000, a ? (4'b0001 << o) : 4'b0000, 1'b1, 1'b1, o, dat(o));
  endtask

  int n;
  int beats;

  initial begin
    rst_n   = 1'b0;
    req     = 4'b0000;
    acc     = 1'b0;
    data_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    // ---- vector table ----
    // Single requester, accept pulses 1 high / 1 low.
    idle(4'b0001, 1'b0, 2'd3);
    grant(4'b0000, 1'b0, 2'd0);
    for (int k = 0; k < 8; k++) begin
      xfer(4'b0000, 1'b1, 2'd0);
      if (k < 7) xfer(4'b0000, 1'b0, 2'd0);
    end
    idle(4'b0000, 1'b0, 2'd0);
    // Reset back to pointer 3, then req=0101 held over three bursts with
    // accepted_in held high (ignored outside XFER).
    v(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00);
    idle(4'b0101, 1'b1, 2'd3);
    grant(4'b0101, 1'b1, 2'd0);
    for (int k = 0; k < 8; k++) xfer(4'b0101, 1'b1, 2'd0);
    idle(4'b0101, 1'b1, 2'd0);
    grant(4'b0101, 1'b1, 2'd2);
    for (int k = 0; k < 8; k++) xfer(4'b0101, 1'b1, 2'd2);
    idle(4'b0101, 1'b1, 2'd2);
    grant(4'b0101, 1'b1, 2'd0);
    for (int k = 0; k < 8; k++) xfer(4'b0000, 1'b1, 2'd0);
    idle(4'b0000, 1'b0, 2'd0);
    // Others request during owner 0's burst: no preemption, then owner 1.
    idle(4'b0001, 1'b0, 2'd0);
    grant(4'b1110, 1'b0, 2'd0);
    for (int k = 0; k < 8; k++) begin
      xfer(4'b1110, 1'b1, 2'd0);
      if (k < 7) xfer(4'b1110, 1'b0, 2'd0);
    end
    idle(4'b1110, 1'b0, 2'd0);
    grant(4'b0000, 1'b0, 2'd1);
    for (int k = 0; k < 3; k++) xfer(4'b0000, 1'b1, 2'd1);
    // Reset after 3 beats: cycle still shows XFER, then everything clears.
    v(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd1, 8'hB1);
    // accepted_in while IDLE is ignored.
    idle(4'b0000, 1'b1, 2'd3);
    idle(4'b0000, 1'b1, 2'd3);
    idle(4'b0000, 1'b0, 2'd3);
    // Fresh grant to requester 1 takes a full 8 beats.
    idle(4'b0010, 1'b0, 2'd3);
    grant(4'b0000, 1'b0, 2'd1);
    for (int k = 0; k < 8; k++) xfer(4'b0000, 1'b1, 2'd1);
    idle(4'b0000, 1'b0, 2'd1);

    // ---- initial reset ----
    repeat (2) @(posedge clk);
    #1;
    #3;
    chk("reset_gnt", gnt, 4'b0000);
    chk("reset_acco", acco, 4'b0000);
    chk("reset_valid", bus_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_owner", owner, 2'd3);
    chk("reset_data", bus_data, 8'h00);
    chk("reset_timeout", timeout_err, 1'b0);
    @(posedge clk);
    #1;

    // ---- apply table ----
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      req   = vecs[i].req;
      acc   = vecs[i].acc;
      #3;
      $display("row %0d rst_n=%0b req=%b acc=%0b -> gnt=%b acco=%b valid=%0b busy=%0b owner=%0d data=%h",
               i, rst_n, req, acc, gnt, acco, bus_valid, busy, owner, bus_data);
      chk($sformatf("row%0d_gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("row%0d_acco", i), acco, vecs[i].acco);
      chk($sformatf("row%0d_valid", i), bus_valid, vecs[i].valid);
      chk($sformatf("row%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("row%0d_owner", i), owner, vecs[i].owner);
      chk($sformatf("row%0d_data", i), bus_data, vecs[i].data);
      chk($sformatf("row%0d_timeout", i), timeout_err, 1'b0);
      @(posedge clk);
      #1;
    end

    // ---- hand sequence: grant latency, live data pass-through, burst length ----
    // Pointer is 1, so req=0100 must go to requester 2 after one edge.
    req = 4'b0100;
    acc = 1'b0;
    n   = 0;
    #3;
    while (gnt == 4'b0000 && n < 5) begin
      @(posedge clk);
      #4;
      n++;
    end
    $display("seq grant: req=0100 latency=%0d gnt=%b owner=%0d", n, gnt, owner);
    chk("seq_gnt_latency", n, 1);
    chk("seq_gnt", gnt, 4'b0100);
    chk("seq_owner", owner, 2'd2);
    req = 4'b0000;
    @(posedge clk);
    #1;
    data_in[23:16] = 8'h5E;
    acc = 1'b1;
    #3;
    chk("seq_live_data", bus_data, 8'h5E);
    chk("seq_live_acco", acco, 4'b0100);
    beats = 0;
    while (busy && beats < 20) begin
      @(posedge clk);
      #4;
      beats++;
    end
    $display("seq burst: beats=%0d busy=%0b valid=%0b data=%h", beats, busy, bus_valid, bus_data);
    chk("seq_burst_len", beats, 8);
    chk("seq_end_valid", bus_valid, 1'b0);
    chk("seq_end_data", bus_data, 8'h00);
    chk("seq_end_acco", acco, 4'b0000);
    acc = 1'b0;
    data_in[23:16] = 8'hC2;
    @(posedge clk);
    #1;

`ifdef IAB_ARB_TIMEOUT_EN
    // ---- hand sequence: watchdog abort after 16 idle XFER edges ----
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b0001;
    @(posedge clk);
    #1;
    req = 4'b0011;
    @(posedge clk);
    #1;
    repeat (15) @(posedge clk);
    #3;
    chk("to_before_err", timeout_err, 1'b0);
    chk("to_before_busy", busy, 1'b1);
    @(posedge clk);
    #3;
    $display("seq timeout: timeout_err=%0b busy=%0b valid=%0b", timeout_err, busy, bus_valid);
    chk("to_err", timeout_err, 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_valid", bus_valid, 1'b0);
    @(posedge clk);
    #3;
    $display("seq after timeout: gnt=%b owner=%0d timeout_err=%0b", gnt, owner, timeout_err);
    chk("to_next_gnt", gnt, 4'b0010);
    chk("to_next_owner", owner, 2'd1);
    chk("to_err_pulse", timeout_err, 1'b0);
    req = 4'b0000;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
